store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 36 +++
 rtl/store_buffer_match.sv | 39 +++
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and its match logic.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    // Last byte offset covered by a full-word access.
    localparam logic [ADDR_W:0] WORD_SPAN = (ADDR_W+1)'(3);

    // One buffered store: valid flag plus word address and data.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sbEntry_t;

    // What the data memory port is doing this cycle.
    typedef enum logic [1:0] {
        DM_IDLE  = 2'd0,
        DM_DRAIN = 2'd1,
        DM_LOAD  = 2'd2
    } dmOp_e;

    // True when the 4-byte windows starting at a and b share any byte.
    // Widened by one bit so a window near the top of memory cannot wrap.
    function automatic logic wordsOverlap(input logic [ADDR_W-1:0] a,
                                          input logic [ADDR_W-1:0] b);
        logic [ADDR_W:0] wa;
        logic [ADDR_W:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa <= wb + WORD_SPAN) && (wb <= wa + WORD_SPAN);
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Compares a load address against every buffered store: reports the
// youngest exact hit and whether any entry only partially overlaps.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sbEntry_t                   i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [ADDR_W-1:0]          i_addr,
    output logic                       o_hit,
    output logic [DATA_W-1:0]          o_hitData,
    output logic                       o_overlap
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    // Walk entries oldest to youngest from head so the last exact hit wins.
    always_comb begin
        o_hit     = 1'b0;
        o_hitData = '0;
        o_overlap = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_entries[w_idx].valid) begin
                if (i_entries[w_idx].addr == i_addr) begin
                    o_hit     = 1'b1;
                    o_hitData = i_entries[w_idx].data;
                end else if (wordsOverlap(i_entries[w_idx].addr, i_addr)) begin
                    o_overlap = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory: queues
// stores, drains them when the memory port is free, forwards exact hits.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       memread_i,
    input  logic                       memwrite_i,
    input  logic [ADDR_W-1:0]          memaddr_i,
    input  logic [DATA_W-1:0]          writedata_i,
    input  logic                       fence_i,
    output logic [DATA_W-1:0]          memdata_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       dm_memread_o,
    output logic                       dm_memwrite_o,
    output logic [ADDR_W-1:0]          dm_memaddr_o,
    output logic [DATA_W-1:0]          dm_writedata_o,
    input  logic [DATA_W-1:0]          dm_memdata_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sbEntry_t          r_entries [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_load;
    logic              w_hit;
    logic              w_overlap;
    logic              w_overlapStall;
    logic              w_notEmpty;
    logic              w_full;
    logic              w_drain;
    logic              w_stall;
    logic              w_enq;
    logic [DATA_W-1:0] w_hitData;
    dmOp_e             w_dmOp;

    store_buffer_match #(.DEPTH(DEPTH)) u_match (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_addr    (memaddr_i),
        .o_hit     (w_hit),
        .o_hitData (w_hitData),
        .o_overlap (w_overlap)
    );

    // A request with both read and write set is a store; its load half is dropped.
    assign w_load         = memread_i & ~memwrite_i;
    assign w_overlapStall = w_load & w_overlap;
    assign w_notEmpty     = (r_count != '0);
    assign w_full         = (r_count == CNT_W'(DEPTH));

    // The port is free whenever no load is asked for; overlap and fence force it.
    assign w_drain = w_notEmpty & (~memread_i | w_overlapStall | fence_i);

    // Full only blocks a store that cannot make room; a load on a full
    // buffer must not stall, since it would never let the buffer drain.
    assign w_stall = (w_full & memwrite_i & ~w_drain)
                   | w_overlapStall
                   | (fence_i & w_notEmpty);

    assign w_enq   = memwrite_i & ~w_stall;
    assign stall_o = w_stall;
    assign count_o = r_count;

    // Choose what the data memory port does: drain beats load beats idle.
    always_comb begin
        w_dmOp         = DM_IDLE;
        dm_memread_o   = 1'b0;
        dm_memwrite_o  = 1'b0;
        dm_memaddr_o   = '0;
        dm_writedata_o = '0;
        if (w_drain) begin
            w_dmOp = DM_DRAIN;
        end else if (w_load) begin
            w_dmOp = DM_LOAD;
        end
        case (w_dmOp)
            DM_DRAIN: begin
                dm_memwrite_o  = 1'b1;
                dm_memaddr_o   = r_entries[r_head].addr;
                dm_writedata_o = r_entries[r_head].data;
            end
            DM_LOAD: begin
                dm_memread_o = 1'b1;
                dm_memaddr_o = memaddr_i;
            end
            default: begin
                dm_memread_o = 1'b0;
            end
        endcase
    end

    // Load data: forwarded buffer hit, else memory, zero when stalled or no load.
    always_comb begin
        memdata_o = '0;
        if (w_load && !w_stall) begin
            memdata_o = w_hit ? w_hitData : dm_memdata_i;
        end
    end

    // FIFO state: pop at head on drain, push at tail on an accepted store.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            if (w_enq) begin
                r_entries[r_tail] <= {1'b1, memaddr_i, writedata_i};
                r_tail            <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer with hand sequences for
// reset discard and multi-entry overlap draining.
module tb_store_buffer;

    logic        clk_i;
    logic        rst_i;
    logic        memread_i;
    logic        memwrite_i;
    logic [31:0] memaddr_i;
    logic [31:0] writedata_i;
    logic        fence_i;
    logic [31:0] memdata_o;
    logic        stall_o;
    logic [2:0]  count_o;
    logic        dm_memread_o;
    logic        dm_memwrite_o;
    logic [31:0] dm_memaddr_o;
    logic [31:0] dm_writedata_o;
    logic [31:0] dm_memdata_i;

    int compares;
    int failures;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        fence;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dmData;
        logic [31:0] expMem;
        logic        expStall;
        logic [2:0]  expCount;
        logic        expDmRd;
        logic        expDmWr;
        logic [31:0] expDmAddr;
        logic [31:0] expDmWdata;
    } vec_t;

    vec_t vecs[$];

    store_buffer #(.DEPTH(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .memread_i      (memread_i),
        .memwrite_i     (memwrite_i),
        .memaddr_i      (memaddr_i),
        .writedata_i    (writedata_i),
        .fence_i        (fence_i),
        .memdata_o      (memdata_o),
        .stall_o        (stall_o),
        .count_o        (count_o),
        .dm_memread_o   (dm_memread_o),
        .dm_memwrite_o  (dm_memwrite_o),
        .dm_memaddr_o   (dm_memaddr_o),
        .dm_writedata_o (dm_writedata_o),
        .dm_memdata_i   (dm_memdata_i)
    );

    // Free-running 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic fence,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] dmData);
        @(negedge clk_i);
        memread_i    = rd;
        memwrite_i   = wr;
        fence_i      = fence;
        memaddr_i    = addr;
        writedata_i  = wdata;
        dm_memdata_i = dmData;
        #1;
    endtask

    function automatic void addVec(input logic rd, input logic wr, input logic fence,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] dmData, input logic [31:0] expMem,
                                   input logic expStall, input logic [2:0] expCount,
                                   input logic expDmRd, input logic expDmWr,
                                   input logic [31:0] expDmAddr,
                                   input logic [31:0] expDmWdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.fence = fence; v.addr = addr; v.wdata = wdata;
        v.dmData = dmData; v.expMem = expMem; v.expStall = expStall;
        v.expCount = expCount; v.expDmRd = expDmRd; v.expDmWr = expDmWr;
        v.expDmAddr = expDmAddr; v.expDmWdata = expDmWdata;
        vecs.push_back(v);
    endfunction

    initial begin
        int stallCycles;
        compares     = 0;
        failures     = 0;
        rst_i        = 1'b1;
        memread_i    = 1'b0;
        memwrite_i   = 1'b0;
        fence_i      = 1'b0;
        memaddr_i    = '0;
        writedata_i  = '0;
        dm_memdata_i = '0;

        //     rd wr f  addr      wdata         dmData        expMem        st cnt dRd dWr dAddr     dWdata
        addVec(0, 0, 0, 32'h00, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h00, 32'h0);
        addVec(0, 1, 0, 32'h04, 32'h11223344, 32'h0,        32'h0,        0, 0, 0, 0, 32'h00, 32'h0);
        addVec(1, 0, 0, 32'h04, 32'h0,        32'hCAFEF00D, 32'h11223344, 0, 1, 1, 0, 32'h04, 32'h0);
        addVec(1, 1, 0, 32'h08, 32'hAAAA0001, 32'h0,        32'h0,        0, 1, 0, 0, 32'h00, 32'h0);
        addVec(1, 1, 0, 32'h08, 32'hAAAA0002, 32'h0,        32'h0,        0, 2, 0, 0, 32'h00, 32'h0);
        addVec(1, 0, 0, 32'h08, 32'h0,        32'hCAFEF00D, 32'hAAAA0002, 0, 3, 1, 0, 32'h08, 32'h0);
        addVec(1, 0, 0, 32'h04, 32'h0,        32'hCAFEF00D, 32'h11223344, 0, 3, 1, 0, 32'h04, 32'h0);
        addVec(0, 0, 1, 32'h00, 32'h0,        32'h0,        32'h0,        1, 3, 0, 1, 32'h04, 32'h11223344);
        addVec(0, 0, 1, 32'h00, 32'h0,        32'h0,        32'h0,        1, 2, 0, 1, 32'h08, 32'hAAAA0001);
        addVec(0, 0, 1, 32'h00, 32'h0,        32'h0,        32'h0,        1, 1, 0, 1, 32'h08, 32'hAAAA0002);
        addVec(0, 0, 1, 32'h00, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h00, 32'h0);
        addVec(1, 1, 0, 32'h04, 32'h44440004, 32'h0,        32'h0,        0, 0, 0, 0, 32'h00, 32'h0);
        addVec(1, 0, 0, 32'h100, 32'h0,       32'h0BADBEEF, 32'h0BADBEEF, 0, 1, 1, 0, 32'h100, 32'h0);
        addVec(1, 1, 0, 32'h10, 32'h44440010, 32'h0,        32'h0,        0, 1, 0, 0, 32'h00, 32'h0);
        addVec(1, 0, 0, 32'h200, 32'h0,       32'h12345678, 32'h12345678, 0, 2, 1, 0, 32'h200, 32'h0);
        addVec(1, 1, 0, 32'h20, 32'h44440020, 32'h0,        32'h0,        0, 2, 0, 0, 32'h00, 32'h0);
        addVec(1, 1, 0, 32'h30, 32'h44440030, 32'h0,        32'h0,        0, 3, 0, 0, 32'h00, 32'h0);
        addVec(1, 0, 0, 32'h06, 32'h0,        32'h5555AAAA, 32'h0,        1, 4, 0, 1, 32'h04, 32'h44440004);
        addVec(1, 0, 0, 32'h06, 32'h0,        32'h5555AAAA, 32'h5555AAAA, 0, 3, 1, 0, 32'h06, 32'h0);
        addVec(1, 1, 0, 32'h40, 32'h44440040, 32'h0,        32'h0,        0, 3, 0, 0, 32'h00, 32'h0);
        addVec(0, 1, 0, 32'h50, 32'h44440050, 32'h0,        32'h0,        0, 4, 0, 1, 32'h10, 32'h44440010);
        addVec(1, 1, 0, 32'h60, 32'h44440060, 32'h0,        32'h0,        1, 4, 0, 0, 32'h00, 32'h0);
        addVec(0, 0, 0, 32'h00, 32'h0,        32'h0,        32'h0,        0, 4, 0, 1, 32'h20, 32'h44440020);
        addVec(0, 0, 0, 32'h00, 32'h0,        32'h0,        32'h0,        0, 3, 0, 1, 32'h30, 32'h44440030);

        // Reset state.
        @(negedge clk_i);
        #1;
        checkOutput("reset count", 32'(count_o), 32'd0);
        checkOutput("reset stall", 32'(stall_o), 32'd0);
        checkOutput("reset dmWr", 32'(dm_memwrite_o), 32'd0);
        checkOutput("reset memdata", memdata_o, 32'h0);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].fence, vecs[i].addr,
                          vecs[i].wdata, vecs[i].dmData);
            checkOutput($sformatf("v%0d memdata", i), memdata_o, vecs[i].expMem);
            checkOutput($sformatf("v%0d stall", i), 32'(stall_o), 32'(vecs[i].expStall));
            checkOutput($sformatf("v%0d count", i), 32'(count_o), 32'(vecs[i].expCount));
            checkOutput($sformatf("v%0d dmRd", i), 32'(dm_memread_o), 32'(vecs[i].expDmRd));
            checkOutput($sformatf("v%0d dmWr", i), 32'(dm_memwrite_o), 32'(vecs[i].expDmWr));
            checkOutput($sformatf("v%0d dmAddr", i), dm_memaddr_o, vecs[i].expDmAddr);
            checkOutput($sformatf("v%0d dmWdata", i), dm_writedata_o, vecs[i].expDmWdata);
        end

        // Reset in the middle of a cycle with two entries (0x40, 0x50) buffered.
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
        checkOutput("prerst count", 32'(count_o), 32'd2);
        checkOutput("prerst dmWr", 32'(dm_memwrite_o), 32'd1);
        checkOutput("prerst dmAddr", dm_memaddr_o, 32'h40);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("midrst count", 32'(count_o), 32'd0);
        checkOutput("midrst dmWr", 32'(dm_memwrite_o), 32'd0);
        checkOutput("midrst dmAddr", dm_memaddr_o, 32'h0);
        checkOutput("midrst stall", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("inrst dmWr", 32'(dm_memwrite_o), 32'd0);
        rst_i = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
        checkOutput("postrst count", 32'(count_o), 32'd0);
        checkOutput("postrst dmWr", 32'(dm_memwrite_o), 32'd0);
        applyStimulus(1, 0, 0, 32'h40, 32'h0, 32'h77778888);
        checkOutput("postrst ld40 memdata", memdata_o, 32'h77778888);
        checkOutput("postrst ld40 dmRd", 32'(dm_memread_o), 32'd1);
        applyStimulus(1, 0, 0, 32'h04, 32'h0, 32'h66665555);
        checkOutput("postrst ld04 memdata", memdata_o, 32'h66665555);
        checkOutput("postrst ld04 stall", 32'(stall_o), 32'd0);

        // Load at 0x06 overlaps both 0x04 and 0x08: two drain cycles expected.
        applyStimulus(1, 1, 0, 32'h04, 32'hBBBB0004, 32'h0);
        applyStimulus(1, 1, 0, 32'h08, 32'hBBBB0008, 32'h0);
        applyStimulus(1, 0, 0, 32'h06, 32'h0, 32'h99990006);
        stallCycles = 0;
        while (stall_o && stallCycles < 10) begin
            stallCycles++;
            @(negedge clk_i);
            #1;
        end
        checkOutput("overlap stall cycles", 32'(stallCycles), 32'd2);
        checkOutput("overlap stall released", 32'(stall_o), 32'd0);
        checkOutput("overlap count", 32'(count_o), 32'd0);
        checkOutput("overlap memdata", memdata_o, 32'h99990006);

        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, failures);
        $finish;
    end

endmodule
